// File: rtl/timer32_pkg.sv
// Shared constants for the 32-bit timer register front-end.
//   - word offsets (PADDR[4:2]) of each register
//   - STATUS bit positions
//   - default reset value of the compare register
package timer32_pkg;

  // Word offsets, i.e. byte offset >> 2.
  localparam logic [2:0] TMR_OFF   = 3'd0;  // 0x00
  localparam logic [2:0] PRE_OFF   = 3'd1;  // 0x04
  localparam logic [2:0] CMP_OFF   = 3'd2;  // 0x08
  localparam logic [2:0] CTRL_OFF  = 3'd3;  // 0x0C
  localparam logic [2:0] STAT_OFF  = 3'd4;  // 0x10
  localparam logic [2:0] IM_OFF    = 3'd5;  // 0x14
  localparam logic [2:0] OVCNT_OFF = 3'd6;  // 0x18
  localparam logic [2:0] UNMAP_OFF = 3'd7;  // 0x1C, reserved

  // STATUS bit indices.
  localparam int unsigned ST_OV   = 0;
  localparam int unsigned ST_PEND = 1;

  localparam logic [31:0] CMP_RST_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer32_ov_evt.sv
// Overflow event tracking for the timer register front-end.
//   clk, rst_n : clock, async active-low reset
//   tmrov_i    : core overflow flag (level)
//   pend_clr   : clear request for the sticky pending bit
//   cnt_clr    : clear request for the overflow-event counter
//   pend       : sticky pending flag, set on each rising edge of tmrov_i
//   ovcnt      : saturating count of tmrov_i rising edges
module timer32_ov_evt #(
  parameter int unsigned OVCNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tmrov_i,
  input  logic               pend_clr,
  input  logic               cnt_clr,
  output logic               pend,
  output logic [OVCNT_W-1:0] ovcnt
);

  localparam logic [OVCNT_W-1:0] CntMax = '1;

  logic               ov_q;
  logic               ov_rise;
  logic               pend_q, pend_d;
  logic [OVCNT_W-1:0] cnt_q, cnt_d;

  assign ov_rise = tmrov_i & ~ov_q;

  always_comb begin
    // A new overflow outranks a simultaneous software clear.
    pend_d = pend_q;
    if (pend_clr) pend_d = 1'b0;
    if (ov_rise)  pend_d = 1'b1;

    // Clear coincident with a rise leaves exactly that one event counted.
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = ov_rise ? OVCNT_W'(1) : '0;
    end else if (ov_rise && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + OVCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q   <= 1'b0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ov_q   <= tmrov_i;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend  = pend_q;
  assign ovcnt = cnt_q;

endmodule

// File: rtl/apb_timer32_regs.sv
// APB3 register front-end for the 32-bit prescaled timer core.
//   clk, rst_n         : clock, async active-low reset
//   PSEL..PWDATA       : APB3 request (only PADDR[4:2] decoded)
//   PRDATA/PREADY/PSLVERR : APB3 response, zero wait states
//   tmr_i, tmrov_i     : core count and overflow flag
//   pre_o, tmrcmp_o, tmren_o, tmrovclr_o : core controls
//   irq                : level interrupt, registered PEND & IM[0]
module apb_timer32_regs
  import timer32_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned OVCNT_W = 16,
  parameter logic [31:0] CMP_RST = CMP_RST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [31:0]       tmr_i,
  input  logic              tmrov_i,
  output logic [31:0]       pre_o,
  output logic [31:0]       tmrcmp_o,
  output logic              tmren_o,
  output logic              tmrovclr_o,
  output logic              irq
);

  logic       access, wr, rd;
  logic [2:0] addr;
  logic       unused_paddr;

  assign access       = PSEL & PENABLE;
  assign wr           = access & PWRITE;
  assign rd           = access & ~PWRITE;
  assign addr         = PADDR[4:2];
  assign unused_paddr = ^PADDR;

  logic [31:0] pre_q, cmp_q;
  logic        en_q, im_q, clr_q, irq_q;
  logic        pend, pend_clr, cnt_clr;
  logic [OVCNT_W-1:0] ovcnt;

  assign pend_clr = wr && (addr == STAT_OFF) && PWDATA[ST_PEND];
  assign cnt_clr  = wr && (addr == OVCNT_OFF);

  timer32_ov_evt #(
    .OVCNT_W (OVCNT_W)
  ) u_ov_evt (
    .clk      (clk),
    .rst_n    (rst_n),
    .tmrov_i  (tmrov_i),
    .pend_clr (pend_clr),
    .cnt_clr  (cnt_clr),
    .pend     (pend),
    .ovcnt    (ovcnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cmp_q <= CMP_RST;
      en_q  <= 1'b0;
      im_q  <= 1'b0;
      clr_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr) begin
        case (addr)
          PRE_OFF:  pre_q <= PWDATA;
          CMP_OFF:  cmp_q <= PWDATA;
          CTRL_OFF: en_q  <= PWDATA[0];
          IM_OFF:   im_q  <= PWDATA[0];
          default:  ;
        endcase
      end
      clr_q <= wr && (addr == STAT_OFF) && PWDATA[ST_OV];
      irq_q <= pend & im_q;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      case (addr)
        TMR_OFF:   PRDATA = tmr_i;
        PRE_OFF:   PRDATA = pre_q;
        CMP_OFF:   PRDATA = cmp_q;
        CTRL_OFF:  PRDATA[0] = en_q;
        STAT_OFF: begin
          PRDATA[ST_OV]   = tmrov_i;
          PRDATA[ST_PEND] = pend;
        end
        IM_OFF:    PRDATA[0] = im_q;
        OVCNT_OFF: PRDATA[OVCNT_W-1:0] = ovcnt;
        default:   ;
      endcase
    end
  end

  assign PREADY     = 1'b1;
  assign PSLVERR    = access && (addr == UNMAP_OFF);
  assign pre_o      = pre_q;
  assign tmrcmp_o   = cmp_q;
  assign tmren_o    = en_q;
  assign tmrovclr_o = clr_q;
  assign irq        = irq_q;

endmodule
